// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch plus branch / jr / j redirects, with a
// pending-redirect state while instruction memory is busy. Define JUMP_SIGN_EXT_EN for sign-extended jump targets.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             ImemReady,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic             JumpEn,
  input  logic [25:0]      JumpIndex,
  input  logic [31:0]      JumpPCPlus4,
  input  logic             JrEn,
  input  logic [31:0]      JrTarget,
  output logic [31:0]      PCResult,
  output logic             FetchValid,
  output logic             FlushIF,
  output logic             FlushID,
  output logic             MisalignErr,
  output logic [CNT_W-1:0] RedirectCount
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        br_acc, jr_acc, jmp_acc, redirect;
  logic [3:0]  jump_upper;
  logic [31:0] jump_target, raw_target, target;

`ifdef JUMP_SIGN_EXT_EN
  logic [31:0] unused_jump_pc;
  assign unused_jump_pc = JumpPCPlus4;
  assign jump_upper     = {4{JumpIndex[25]}};
`else
  logic [27:0] unused_jump_pc;
  assign unused_jump_pc = JumpPCPlus4[27:0];
  assign jump_upper     = JumpPCPlus4[31:28];
`endif

  // ID-stage requests only count when ID is not stalled; a stalled instruction re-presents.
  always_comb begin
    br_acc      = (state_q == RUN) && BranchTaken;
    jr_acc      = (state_q == RUN) && !BranchTaken && JrEn && !Stall;
    jmp_acc     = (state_q == RUN) && !BranchTaken && !JrEn && JumpEn && !Stall;
    redirect    = br_acc || jr_acc || jmp_acc;
    jump_target = {jump_upper, JumpIndex, 2'b00};
    if (br_acc) begin
      raw_target = BranchTarget;
    end else if (jr_acc) begin
      raw_target = JrTarget;
    end else begin
      raw_target = jump_target;
    end
    target = {raw_target[31:2], 2'b00};
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          if (ImemReady) begin
            pc_d = target;
          end else begin
            pend_d  = target;
            state_d = PEND;
          end
        end else if (ImemReady && !Stall) begin
          pc_d = pc_q + 32'd4;
        end
      end
      PEND: begin
        if (ImemReady) begin
          pc_d    = pend_q;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= 32'h0000_0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes follow the inputs in the accepting cycle; suppressed while reset is held.
  assign PCResult      = pc_q;
  assign FetchValid    = (state_q == RUN);
  assign FlushIF       = redirect && !Reset;
  assign FlushID       = br_acc && !Reset;
  assign MisalignErr   = redirect && (raw_target[1:0] != 2'b00) && !Reset;
  assign RedirectCount = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected fetch addresses are queued when a
// request is driven and compared once the clock edge has applied it.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        ImemReady = 1'b1;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        JumpEn = 1'b0;
  logic [25:0] JumpIndex = 26'h0;
  logic [31:0] JumpPCPlus4 = 32'h0;
  logic        JrEn = 1'b0;
  logic [31:0] JrTarget = 32'h0;
  logic [31:0] PCResult;
  logic        FetchValid;
  logic        FlushIF;
  logic        FlushID;
  logic        MisalignErr;
  logic [15:0] RedirectCount;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [15:0] exp_cnt;
  int          n_checks = 0;
  int          n_fail = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .ImemReady(ImemReady),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .JumpEn(JumpEn), .JumpIndex(JumpIndex), .JumpPCPlus4(JumpPCPlus4),
    .JrEn(JrEn), .JrTarget(JrTarget), .PCResult(PCResult), .FetchValid(FetchValid),
    .FlushIF(FlushIF), .FlushID(FlushID), .MisalignErr(MisalignErr),
    .RedirectCount(RedirectCount)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic clear_req();
    BranchTaken = 1'b0;
    JumpEn      = 1'b0;
    JrEn        = 1'b0;
    Stall       = 1'b0;
    ImemReady   = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h0000_0203;
    @(negedge Clk); #1;
    n_checks++; if (PCResult !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", PCResult, 32'h0); end
    n_checks++; if (FetchValid !== 1'b1) begin n_fail++; $display("FAIL reset_fetchvalid: got %b expected 1", FetchValid); end
    n_checks++; if ({FlushIF, FlushID, MisalignErr} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b expected 000", {FlushIF, FlushID, MisalignErr}); end
    n_checks++; if (RedirectCount !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", RedirectCount); end
    clear_req();
    tick();
    Reset   = 1'b0;
    exp_cnt = 16'd0;
    $display("txn reset: PCResult=%h FetchValid=%b", PCResult, FetchValid);
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
    for (int i = 0; i < 4; i++) begin
      exp_pc = exp_q.pop_front();
      n_checks++; if (PCResult !== exp_pc) begin n_fail++; $display("FAIL seq_pc: got %h expected %h", PCResult, exp_pc); end
      n_checks++; if (FetchValid !== 1'b1) begin n_fail++; $display("FAIL seq_fetchvalid: got %b expected 1", FetchValid); end
      $display("txn seq: PCResult=%h", PCResult);
      tick();
    end
  endtask

  task automatic test_branch_priority();
    BranchTaken = 1'b1; BranchTarget = 32'h0000_0200;
    JumpEn = 1'b1; JumpIndex = 26'h0000_0AA; JumpPCPlus4 = 32'h0000_0014;
    #1;
    n_checks++; if ({FlushIF, FlushID} !== 2'b11) begin n_fail++; $display("FAIL branch_flush: got %b expected 11", {FlushIF, FlushID}); end
    exp_q.push_back(32'h0000_0200); exp_cnt++;
    tick(); clear_req();
    exp_pc = exp_q.pop_front();
    n_checks++; if (PCResult !== exp_pc) begin n_fail++; $display("FAIL branch_pc: got %h expected %h", PCResult, exp_pc); end
    n_checks++; if (RedirectCount !== exp_cnt) begin n_fail++; $display("FAIL branch_count: got %0d expected %0d", RedirectCount, exp_cnt); end
    $display("txn branch: PCResult=%h count=%0d", PCResult, RedirectCount);
  endtask

  task automatic test_jump();
    JumpEn = 1'b1; JumpIndex = 26'h200_0001; JumpPCPlus4 = 32'h1000_0008;
    #1;
    n_checks++; if ({FlushIF, FlushID} !== 2'b10) begin n_fail++; $display("FAIL jump_flush: got %b expected 10", {FlushIF, FlushID}); end
`ifdef JUMP_SIGN_EXT_EN
    exp_q.push_back(32'hF800_0004);
`else
    exp_q.push_back(32'h1800_0004);
`endif
    exp_cnt++;
    tick(); clear_req();
    exp_pc = exp_q.pop_front();
    n_checks++; if (PCResult !== exp_pc) begin n_fail++; $display("FAIL jump_pc: got %h expected %h", PCResult, exp_pc); end
    n_checks++; if (RedirectCount !== exp_cnt) begin n_fail++; $display("FAIL jump_count: got %0d expected %0d", RedirectCount, exp_cnt); end
    $display("txn jump: PCResult=%h", PCResult);
  endtask

  task automatic test_jump_stall();
    Stall = 1'b1; JumpEn = 1'b1; JumpIndex = 26'h000_0040; JumpPCPlus4 = 32'h0000_0104;
    #1;
    n_checks++; if (FlushIF !== 1'b0) begin n_fail++; $display("FAIL stall_flush: got %b expected 0", FlushIF); end
    exp_q.push_back(exp_pc);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++; if (PCResult !== exp_pc) begin n_fail++; $display("FAIL stall_hold: got %h expected %h", PCResult, exp_pc); end
    Stall = 1'b0;
    #1;
    n_checks++; if (FlushIF !== 1'b1) begin n_fail++; $display("FAIL unstall_flush: got %b expected 1", FlushIF); end
    exp_q.push_back(32'h0000_0100); exp_cnt++;
    tick(); clear_req();
    exp_pc = exp_q.pop_front();
    n_checks++; if (PCResult !== exp_pc) begin n_fail++; $display("FAIL unstall_pc: got %h expected %h", PCResult, exp_pc); end
    n_checks++; if (RedirectCount !== exp_cnt) begin n_fail++; $display("FAIL unstall_count: got %0d expected %0d", RedirectCount, exp_cnt); end
    $display("txn jump_stall: PCResult=%h", PCResult);
  endtask

  task automatic test_pend();
    Stall = 1'b1; ImemReady = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h0000_0300;
    #1;
    n_checks++; if ({FlushIF, FlushID} !== 2'b11) begin n_fail++; $display("FAIL pend_accept_flush: got %b expected 11", {FlushIF, FlushID}); end
    exp_q.push_back(32'h0000_0300); exp_cnt++;
    tick();
    BranchTaken = 1'b0; Stall = 1'b0; JrEn = 1'b1; JrTarget = 32'h0000_0500;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ImemReady = 1'b1;
      #1;
      n_checks++; if (FetchValid !== 1'b0) begin n_fail++; $display("FAIL pend_fetchvalid: got %b expected 0", FetchValid); end
      n_checks++; if (FlushIF !== 1'b0) begin n_fail++; $display("FAIL pend_flush: got %b expected 0", FlushIF); end
      n_checks++; if (PCResult !== 32'h0000_0100) begin n_fail++; $display("FAIL pend_hold: got %h expected %h", PCResult, 32'h0000_0100); end
      tick();
    end
    clear_req();
    exp_pc = exp_q.pop_front();
    n_checks++; if (PCResult !== exp_pc) begin n_fail++; $display("FAIL pend_release_pc: got %h expected %h", PCResult, exp_pc); end
    n_checks++; if (FetchValid !== 1'b1) begin n_fail++; $display("FAIL pend_release_valid: got %b expected 1", FetchValid); end
    n_checks++; if (RedirectCount !== exp_cnt) begin n_fail++; $display("FAIL pend_count: got %0d expected %0d", RedirectCount, exp_cnt); end
    $display("txn pend: PCResult=%h", PCResult);
  endtask

  task automatic test_misalign();
    JrEn = 1'b1; JrTarget = 32'h0000_0103;
    #1;
    n_checks++; if ({FlushIF, FlushID, MisalignErr} !== 3'b101) begin n_fail++; $display("FAIL jr_strobes: got %b expected 101", {FlushIF, FlushID, MisalignErr}); end
    exp_q.push_back(32'h0000_0100); exp_cnt++;
    tick(); clear_req(); #1;
    exp_pc = exp_q.pop_front();
    n_checks++; if (PCResult !== exp_pc) begin n_fail++; $display("FAIL jr_pc: got %h expected %h", PCResult, exp_pc); end
    n_checks++; if (MisalignErr !== 1'b0) begin n_fail++; $display("FAIL jr_misalign_pulse: got %b expected 0", MisalignErr); end
    $display("txn jr: PCResult=%h", PCResult);
  endtask

  task automatic test_back_to_back();
    BranchTaken = 1'b1; BranchTarget = 32'h0000_0040;
    exp_q.push_back(32'h0000_0040); exp_cnt++;
    tick();
    BranchTarget = 32'h0000_0080;
    exp_q.push_back(32'h0000_0080); exp_cnt++;
    exp_pc = exp_q.pop_front();
    n_checks++; if (PCResult !== exp_pc) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", PCResult, exp_pc); end
    tick(); clear_req();
    exp_pc = exp_q.pop_front();
    n_checks++; if (PCResult !== exp_pc) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", PCResult, exp_pc); end
    n_checks++; if (RedirectCount !== exp_cnt) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", RedirectCount, exp_cnt); end
    $display("txn back_to_back: PCResult=%h", PCResult);
  endtask

  task automatic test_wrap();
    BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFC;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0000_0000); exp_cnt++;
    tick(); clear_req();
    exp_pc = exp_q.pop_front();
    n_checks++; if (PCResult !== exp_pc) begin n_fail++; $display("FAIL wrap_top: got %h expected %h", PCResult, exp_pc); end
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++; if (PCResult !== exp_pc) begin n_fail++; $display("FAIL wrap_zero: got %h expected %h", PCResult, exp_pc); end
    $display("txn wrap: PCResult=%h", PCResult);
  endtask

  task automatic test_reset_mid_pend();
    ImemReady = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h0000_0700;
    tick(); clear_req(); ImemReady = 1'b0;
    n_checks++; if (FetchValid !== 1'b0) begin n_fail++; $display("FAIL midpend_state: got %b expected 0", FetchValid); end
    Reset = 1'b1; #1;
    n_checks++; if (PCResult !== 32'h0) begin n_fail++; $display("FAIL midpend_reset_pc: got %h expected 0", PCResult); end
    n_checks++; if (FetchValid !== 1'b1) begin n_fail++; $display("FAIL midpend_reset_valid: got %b expected 1", FetchValid); end
    n_checks++; if (RedirectCount !== 16'd0) begin n_fail++; $display("FAIL midpend_reset_count: got %0d expected 0", RedirectCount); end
    @(negedge Clk);
    Reset = 1'b0; ImemReady = 1'b1;
    exp_q.push_back(32'h0000_0004);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++; if (PCResult !== exp_pc) begin n_fail++; $display("FAIL midpend_after: got %h expected %h", PCResult, exp_pc); end
    $display("txn reset_mid_pend: PCResult=%h", PCResult);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_priority();
    test_jump();
    test_jump_stall();
    test_pend();
    test_misalign();
    test_back_to_back();
    test_wrap();
    test_reset_mid_pend();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-address controller for the pipelined MIPS core. Owns the program counter and sequences it between sequential fetch, EX-stage branch redirects, ID-stage jumps (26-bit index target formed internally), and jump-register. Generates IF/ID flush strobes and holds a pending redirect while instruction memory is not ready. Sits between the hazard unit, the ID/EX control outputs and the instruction memory address port.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
- CNT_W, 16, width of redirect counter
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Stall  in  1  hazard-unit stall of IF/ID
- ImemReady  in  1  instruction memory accepts address this cycle
- BranchTaken  in  1  EX-stage branch resolved taken
- BranchTarget  in  32  EX-stage branch target
- JumpEn  in  1  ID-stage j/jal
- JumpIndex  in  26  instruction[25:0] of the jump
- JumpPCPlus4  in  32  PC+4 of the jump instruction
- JrEn  in  1  ID-stage jr/jalr
- JrTarget  in  32  register value for jr
- PCResult  out  32  fetch address
- FetchValid  out  1  PCResult is a valid fetch this cycle
- FlushIF  out  1  squash IF/ID register
- FlushID  out  1  squash ID/EX register
- MisalignErr  out  1  one-cycle pulse: accepted target had nonzero [1:0]
- RedirectCount  out  CNT_W  accepted redirects, saturating

## Operation
- States: RUN, PEND. Reset: RUN, PCResult=RESET_PC, PendTarget=0, RedirectCount=0; FetchValid=1 and all strobes 0 (strobes are combinational from inputs in RUN, forced 0 in PEND and during Reset).
- Redirect priority in RUN: BranchTaken > JrEn > JumpEn. Lower-priority requests in the same cycle are discarded.
- JumpEn/JrEn accepted only when Stall=0 (stalled ID instruction re-presents). BranchTaken accepted regardless of Stall.
- Branch accept: FlushIF=1, FlushID=1. Jump/Jr accept: FlushIF=1, FlushID=0.
- Jump target: {upper, JumpIndex, 2'b00}; upper per Configuration.
- Every accepted target has [1:0] forced to 00; MisalignErr=1 that cycle if original [1:0]!=0 (jump never misaligned).
- RUN, redirect accepted: ImemReady=1 → PCResult<=target, stay RUN; ImemReady=0 → PendTarget<=target, go PEND.
- RUN, no redirect: ImemReady=1 and Stall=0 → PCResult<=PCResult+4 (mod 2^32, 0xFFFF_FFFC wraps to 0); otherwise hold.
- PEND: FetchValid=0, PCResult held, all redirect inputs ignored, no flushes. ImemReady=1 → PCResult<=PendTarget, go RUN.
- RedirectCount increments by 1 on each accepted redirect; holds at all-ones.

## Timing
- Redirect latency: accepted at edge N → PCResult=target after edge N (ImemReady=1), or one cycle after the first ImemReady=1 in PEND.
- Flush strobes coincide with the accepting cycle, same-cycle combinational.
- Reset asserted mid-PEND: immediately RUN, PCResult=RESET_PC, pending target lost.
- Stall=1 with ImemReady=0 and BranchTaken=1: branch accepted into PEND.

## Configuration
- JUMP_SIGN_EXT_EN defined: jump upper nibble = {4{JumpIndex[25]}} (sign-extended 28-bit offset, consistent with the core's existing jump extension unit).
- Not defined: upper nibble = JumpPCPlus4[31:28] (standard MIPS region jump).

## Test plan
- Reset released, ImemReady=1, no requests, 4 cycles → PCResult 0,4,8,C; FetchValid=1 throughout.
- PC=0x10, BranchTaken=1, BranchTarget=0x200, JumpEn=1 same cycle → next PCResult=0x200, FlushIF=FlushID=1, RedirectCount=1.
- JumpIndex=26'h2000001, JumpPCPlus4=0x1000_0008 → target 0xF800_0004 with JUMP_SIGN_EXT_EN, 0x1800_0004 without; FlushIF=1, FlushID=0.
- JumpEn=1 with Stall=1 → ignored, PC held, no flush; Stall drops → jump taken.
- BranchTaken with ImemReady=0 for 3 cycles → PEND, FetchValid=0, PC held; ImemReady=1 → PCResult=target next cycle; JrEn pulses during PEND ignored.
- JrTarget=0x0000_0103 → PCResult=0x100, MisalignErr pulse; PCResult=0xFFFF_FFFC free-run → 0x0.
